avalon_frame_reader: RTL and testbench

//  Burst-read master driving the 128-bit pixel-conversion read port. Fetches one frame of
//  128-bit words (4 x 32-bit xRGB pixels each), buffers them in an internal FIFO and emits
//  one pixel per clock on a valid/ready stream to the scaler/video output stage.

---
 rtl/avalon_frame_reader.sv | 217 +++++++++++++++++++++
 tb/tb_avalon_frame_reader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_frame_reader.sv
// Burst-read master: fetches a frame of 128-bit words into a FIFO and streams it out
// as one 32-bit xRGB pixel per clock. Bursts are issued only when FIFO space is reserved.
module avalon_frame_reader #(
    parameter int BURST      = 32,
    parameter int FIFO_DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [23:0]  frame_words,
    output logic         busy,
    output logic         done,
    output logic [31:0]  avm_address,
    output logic [6:0]   avm_burstcount,
    output logic         avm_read,
    input  logic [127:0] avm_readdata,
    input  logic         avm_readdatavalid,
    input  logic         avm_waitrequest,
    output logic [31:0]  pix_data,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic         pix_sof,
    output logic         pix_eof
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]  DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [23:0]  BURST_W = 24'(BURST);
    localparam logic [6:0]   BURST_C = 7'(BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t       state_q;
    logic [23:0]  words_left_q;
    logic [31:0]  addr_q;
    logic         eof_seen_q;
    logic         busy_q;
    logic         done_q;
    logic         read_q;
    logic [31:0]  address_q;
    logic [6:0]   bcnt_q;

    logic [127:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] fill_q;
    logic [CW-1:0] fill_d;
    logic [CW-1:0] pend_q;
    logic [CW-1:0] pend_d;

    logic [1:0]   lane_q;
    logic [25:0]  pix_total_q;
    logic [25:0]  pix_cnt_q;
    logic         pv_q;
    logic [31:0]  pdata_q;
    logic         psof_q;
    logic         peof_q;

    logic [127:0] head_w;
    logic [6:0]   len;
    logic [CW:0]  free;
    logic         space_ok;
    logic         frame_go;
    logic         req_acc;
    logic         pix_acc;
    logic         last_acc;
    logic         load;
    logic         pop;

    assign head_w   = mem_q[rd_ptr_q];
    assign frame_go = (state_q == S_IDLE) && start && (frame_words != 24'd0);
    assign req_acc  = read_q && !avm_waitrequest;
    assign pix_acc  = pv_q && pix_ready;
    assign last_acc = pix_acc && peof_q;
    assign load     = (fill_q != '0) && (!pv_q || pix_ready);
    assign pop      = load && (lane_q == 2'd3);

    // Space check counts words already buffered plus beats still owed by the slave.
    always_comb begin
        len      = (words_left_q < BURST_W) ? words_left_q[6:0] : BURST_C;
        free     = DEPTH_C - {1'b0, fill_q} - {1'b0, pend_q};
        space_ok = (32'(free) >= 32'(len));
        fill_d   = fill_q + CW'(avm_readdatavalid) - CW'(pop);
        pend_d   = pend_q + (req_acc ? CW'(bcnt_q) : '0) - CW'(avm_readdatavalid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            addr_q       <= '0;
            eof_seen_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            read_q       <= 1'b0;
            address_q    <= '0;
            bcnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (last_acc) begin
                eof_seen_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_go) begin
                        words_left_q <= frame_words;
                        addr_q       <= '0;
                        eof_seen_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (words_left_q == 24'd0) begin
                        state_q <= S_DRAIN;
                    end else if (space_ok) begin
                        read_q    <= 1'b1;
                        address_q <= addr_q;
                        bcnt_q    <= len;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!avm_waitrequest) begin
                        read_q       <= 1'b0;
                        words_left_q <= words_left_q - 24'(bcnt_q);
                        addr_q       <= addr_q + {24'd0, bcnt_q, 1'b0};
                        state_q      <= S_CHECK;
                    end
                end
                S_DRAIN: begin
                    if ((pend_q == '0) && (eof_seen_q || last_acc)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; every returned beat is written because its slot was reserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            pend_q   <= '0;
        end else begin
            fill_q <= fill_d;
            pend_q <= pend_d;
            if (avm_readdatavalid) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (avm_readdatavalid) begin
            mem_q[wr_ptr_q] <= avm_readdata;
        end
    end

    // Output register: unpacks the FIFO head lane by lane, pixel 0 in [31:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            lane_q      <= '0;
            pix_total_q <= '0;
            pix_cnt_q   <= '0;
            pv_q        <= 1'b0;
            pdata_q     <= '0;
            psof_q      <= 1'b0;
            peof_q      <= 1'b0;
        end else begin
            if (frame_go) begin
                pix_total_q <= {frame_words, 2'b00};
                pix_cnt_q   <= '0;
                lane_q      <= '0;
            end else if (load) begin
                pv_q      <= 1'b1;
                pdata_q   <= {8'h00, head_w[{lane_q, 5'd0} +: 24]};
                psof_q    <= (pix_cnt_q == 26'd0);
                peof_q    <= (pix_cnt_q == pix_total_q - 26'd1);
                pix_cnt_q <= pix_cnt_q + 26'd1;
                lane_q    <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end else if (pix_acc) begin
                pv_q <= 1'b0;
            end
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_read       = read_q;
    assign avm_address    = address_q;
    assign avm_burstcount = bcnt_q;
    assign pix_valid      = pv_q;
    assign pix_data       = pdata_q;
    assign pix_sof        = psof_q;
    assign pix_eof        = peof_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(avm_readdatavalid && (fill_q == CW'(FIFO_DEPTH)) && !pop));
    a_no_unsolicited: assert property (@(posedge clk) disable iff (reset)
        !(avm_readdatavalid && (pend_q == '0)));

endmodule

// File: tb/tb_avalon_frame_reader.sv
// Self-checking bench for avalon_frame_reader: randomised Avalon slave and pixel sink,
// frame-level reference model of bursts and pixel stream.
module tb_avalon_frame_reader;

    localparam int BURST = 32;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [23:0]  frame_words = '0;
    logic         busy, done;
    logic [31:0]  avm_address;
    logic [6:0]   avm_burstcount;
    logic         avm_read;
    logic [127:0] avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;
    logic         avm_waitrequest = 1'b0;
    logic [31:0]  pix_data;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic         pix_sof, pix_eof;

    avalon_frame_reader #(.BURST(BURST), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .frame_words(frame_words),
        .busy(busy), .done(done),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    bit          rst_req = 1'b0;
    int          wait_pct = 0, rdv_pct = 100, ready_pct = 100;
    bit          stall2nd = 1'b0;
    int          stall_ctr = 0;
    int unsigned gen = 0;
    logic [127:0] beat_q[$];
    int          b_addr[$];
    int          b_cnt[$];
    logic [33:0] pix_got[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int unsigned last_acc_cyc = 0, done_cyc = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [6:0]  prev_cnt = '0;

    typedef struct {
        int fw; int ready_p; int wait_p; int rdv_p;
        int exp_nb; int exp_last; bit stall; bit inj;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] word_data(input int unsigned g, input int unsigned w);
        logic [127:0] r;
        for (int l = 0; l < 4; l++)
            r[l*32 +: 32] = (w * 32'h9E3779B1) ^ (g * 32'h85EBCA77)
                          ^ ((l + 1) * 32'hC2B2AE3D) ^ (w << l);
        return r;
    endfunction

    // Slave, sink and monitor share one process so drive/observe ordering is fixed.
    initial begin
        logic wr;
        forever begin
            @(negedge clk);
            if (rst_req) begin
                reset = 1'b1;
                rst_req = 1'b0;
                beat_q.delete();
                avm_readdatavalid = 1'b0;
                avm_waitrequest = 1'b0;
                pix_ready = 1'b0;
                prev_hold = 1'b0;
            end else begin
                reset = 1'b0;
                if (prev_hold)
                    chk("req_hold", {avm_read, avm_burstcount, avm_address},
                        {1'b1, prev_cnt, prev_addr});
                if (beat_q.size() > 0 && $urandom_range(99) < rdv_pct) begin
                    avm_readdata = beat_q.pop_front();
                    avm_readdatavalid = 1'b1;
                end else begin
                    avm_readdata = '0;
                    avm_readdatavalid = 1'b0;
                end
                wr = 1'b0;
                if (avm_read) begin
                    if (stall2nd && b_addr.size() == 1 && stall_ctr < 5) begin
                        wr = 1'b1;
                        stall_ctr++;
                    end else if ($urandom_range(99) < wait_pct) begin
                        wr = 1'b1;
                    end
                end
                avm_waitrequest = wr;
                if (avm_read && !wr) begin
                    b_addr.push_back(int'(avm_address));
                    b_cnt.push_back(int'(avm_burstcount));
                    for (int k = 0; k < int'(avm_burstcount); k++)
                        beat_q.push_back(word_data(gen, avm_address / 2 + k));
                end
                prev_hold = avm_read && wr;
                prev_addr = avm_address;
                prev_cnt = avm_burstcount;
                pix_ready = ($urandom_range(99) < ready_pct);
                if (pix_valid && pix_ready) begin
                    pix_got.push_back({pix_sof, pix_eof, pix_data});
                    if (pix_eof) last_acc_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy) busy_cnt++;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_req = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_bcnt", avm_burstcount, 0);
        chk("rst_pvalid", pix_valid, 0);
        chk("rst_pdata", pix_data, 0);
        chk("rst_sof", pix_sof, 0);
        chk("rst_eof", pix_eof, 0);
    endtask

    task automatic clear_logs();
        b_addr.delete();
        b_cnt.delete();
        pix_got.delete();
        done_cnt = 0;
        busy_cnt = 0;
        stall_ctr = 0;
    endtask

    task automatic start_frame(input int fw);
        @(posedge clk); #1;
        clear_logs();
        gen++;
        start = 1'b1;
        frame_words = 24'(fw);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input int fw, input int bound, input bit inj);
        int m_addr[$];
        int m_cnt[$];
        int left, a, c, np, nb;
        logic [127:0] d;
        logic [33:0] e;
        for (int i = 0; i < bound && done_cnt == 0; i++) begin
            @(posedge clk);
            if (inj && i == 20) begin
                #1;
                start = 1'b1;
                frame_words = 24'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("done_latency", done_cyc, last_acc_cyc + 1);
        chk("busy_after", busy, 0);
        left = fw;
        a = 0;
        while (left > 0) begin
            c = (left < BURST) ? left : BURST;
            m_addr.push_back(a);
            m_cnt.push_back(c);
            a += 2 * c;
            left -= c;
        end
        chk("n_bursts", b_addr.size(), m_addr.size());
        nb = (b_addr.size() < m_addr.size()) ? b_addr.size() : m_addr.size();
        for (int i = 0; i < nb; i++)
            chk("burst", {b_addr[i], b_cnt[i]}, {m_addr[i], m_cnt[i]});
        np = 4 * fw;
        chk("n_pixels", pix_got.size(), np);
        if (pix_got.size() < np) np = pix_got.size();
        for (int p = 0; p < np; p++) begin
            d = word_data(gen, p / 4);
            e = {p == 0, p == 4 * fw - 1, 8'h00, d[(p % 4) * 32 +: 24]};
            chk("pixel", pix_got[p], e);
        end
    endtask

    task automatic run_frame(input vec_t v);
        ready_pct = v.ready_p;
        wait_pct = v.wait_p;
        rdv_pct = v.rdv_p;
        stall2nd = v.stall;
        start_frame(v.fw);
        finish_frame(v.fw, 3000 + v.fw * 60, v.inj);
        if (v.exp_nb > 0) begin
            chk("tbl_nbursts", b_cnt.size(), v.exp_nb);
            if (b_cnt.size() > 0) chk("tbl_last_cnt", b_cnt[b_cnt.size() - 1], v.exp_last);
        end
        if (v.stall) chk("stall_cycles", stall_ctr, 5);
        stall2nd = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        int sum;
        tbl[0] = '{fw: 8,   ready_p: 100, wait_p: 0,  rdv_p: 100, exp_nb: 1,  exp_last: 8,  stall: 0, inj: 0};
        tbl[1] = '{fw: 70,  ready_p: 100, wait_p: 0,  rdv_p: 100, exp_nb: 3,  exp_last: 6,  stall: 0, inj: 0};
        tbl[2] = '{fw: 70,  ready_p: 100, wait_p: 0,  rdv_p: 100, exp_nb: 3,  exp_last: 6,  stall: 1, inj: 0};
        tbl[3] = '{fw: 1,   ready_p: 60,  wait_p: 20, rdv_p: 70,  exp_nb: 1,  exp_last: 1,  stall: 0, inj: 0};
        tbl[4] = '{fw: 32,  ready_p: 50,  wait_p: 30, rdv_p: 50,  exp_nb: 1,  exp_last: 32, stall: 0, inj: 0};
        tbl[5] = '{fw: 33,  ready_p: 80,  wait_p: 10, rdv_p: 80,  exp_nb: 2,  exp_last: 1,  stall: 0, inj: 0};
        tbl[6] = '{fw: 300, ready_p: 70,  wait_p: 20, rdv_p: 60,  exp_nb: 10, exp_last: 12, stall: 0, inj: 1};

        apply_reset();

        for (int i = 0; i < 7; i++) run_frame(tbl[i]);

        // start with zero words must be a silent no-op
        @(posedge clk); #1;
        clear_logs();
        start = 1'b1;
        frame_words = 24'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("zero_no_read", b_addr.size(), 0);
        chk("zero_no_done", done_cnt, 0);
        chk("zero_no_busy", busy_cnt, 0);

        // sink held off: fetch must stop once the FIFO is fully reserved
        ready_pct = 0;
        wait_pct = 0;
        rdv_pct = 100;
        start_frame(1024);
        repeat (1000) @(posedge clk);
        #1;
        sum = 0;
        foreach (b_cnt[i]) sum += b_cnt[i];
        chk("stall_reserved_words", sum, DEPTH);
        chk("stall_no_pixels", pix_got.size(), 0);
        ready_pct = 100;
        finish_frame(1024, 20000, 1'b0);

        // reset with beats still owed by the slave
        ready_pct = 100;
        rdv_pct = 0;
        start_frame(70);
        for (int i = 0; i < 300 && beat_q.size() < 10; i++) @(posedge clk);
        chk("beats_pending", beat_q.size() >= 10, 1);
        apply_reset();
        chk("rst_mid_no_done", done_cnt, 0);
        rdv_pct = 100;
        rv = '{fw: 70, ready_p: 100, wait_p: 0, rdv_p: 100, exp_nb: 3, exp_last: 6, stall: 0, inj: 0};
        run_frame(rv);

        for (int i = 0; i < 4; i++) begin
            rv.fw = $urandom_range(150, 1);
            rv.ready_p = $urandom_range(100, 30);
            rv.wait_p = $urandom_range(50, 0);
            rv.rdv_p = $urandom_range(100, 30);
            rv.exp_nb = 0;
            rv.exp_last = 0;
            rv.stall = 1'b0;
            rv.inj = 1'b0;
            run_frame(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
